plic_gateway: RTL and testbench
===============================

# plic_gateway

Interrupt gateway in front of the PLIC core. Synchronizes raw peripheral interrupt lines (uart, gpio, …) to `wb_clk_i` and converts each into a single pending request: level or rising-edge per source. Holds each source in an IDLE/PENDING/INSERVICE state until the PLIC's claim/complete handshake releases it. Its `pending_o` vector feeds the PLIC pending/priority logic directly.

## Interface
- `NSRC`, 8: number of source slots. Slot 0 is reserved and always 0. Valid IDs are 1..NSRC-1.
- `IDW`, 5: width of the claim/complete ID buses. Requires 2^IDW ≥ NSRC.
- `SYNC_STAGES`, 2: synchronizer depth per source (≥2).
- `wb_clk_i` in 1: single clock; all state updates on its rising edge.
- `wb_rst_n_i` in 1: reset, synchronous, active-low.
- `src_i` in NSRC: raw asynchronous interrupt lines. Bit 0 is ignored.
- `edge_sel_i` in NSRC: per-source mode, 1 = rising-edge, 0 = level-high. Quasi-static; changes take effect next cycle.
- `claim_i` in 1: one-cycle claim strobe from the PLIC.
- `claim_id_i` in IDW: ID being claimed.
- `complete_i` in 1: one-cycle completion strobe from the PLIC.
- `complete_id_i` in IDW: ID being completed.
- `pending_o` out NSRC: registered pending vector to the PLIC.
- `busy_o` out NSRC: registered, 1 while the source is INSERVICE.
- `overrun_o` out NSRC: registered, sticky; a request was lost.

## Operation
- Each source i ≥ 1 passes through a SYNC_STAGES flop chain, giving `s_sync`. A further flop holds `s_prev`.
- Request: `req = edge_sel_i[i] ? (s_sync & ~s_prev) : s_sync`.
- Per-source FSM, states IDLE, PENDING, INSERVICE:
  - IDLE → PENDING when `req`=1.
  - PENDING → INSERVICE when `claim_i` and `claim_id_i`==i.
  - INSERVICE → IDLE when `complete_i` and `complete_id_i`==i. If edge counting (see Configuration) has count > 0, the transition is INSERVICE → PENDING instead.
- Output decode: `pending_o[i]` = (state==PENDING); `busy_o[i]` = (state==INSERVICE).
- `req` while PENDING: merged, with no effect.
- Rising edge while INSERVICE with counting off: dropped, and `overrun_o[i]` is set.
- Level source still high after complete: returns to IDLE, then re-enters PENDING on the following cycle.
- Claim of an ID that is not PENDING is ignored. This includes ID 0 and IDs ≥ NSRC.
- Complete of an ID that is not INSERVICE is ignored.
- Claim and complete in the same cycle with different IDs: both apply. With the same ID, no conflict is possible, because one state excludes the other.
- `overrun_o[i]` clears on a valid complete of i. If a new overrun occurs in the same cycle, set wins.
- Slot 0: all outputs are constant 0.

## Timing
- Reset (`wb_rst_n_i`=0 at a clock edge) clears all sync flops, `s_prev`, every FSM to IDLE, and edge counters to 0. `pending_o`, `busy_o` and `overrun_o` read 0 the cycle after. Reset mid-INSERVICE discards the in-flight interrupt.
- Latency from `src_i` rising (sampled at edge 0) to `pending_o` = 1 is SYNC_STAGES+1 edges. This holds for both modes.
- Claim sampled at edge n: `pending_o`=0 and `busy_o`=1 after edge n.
- Complete sampled at edge n: `busy_o`=0 after edge n.
- Level re-request after complete: `pending_o`=1 after edge n+1.
- Edge pulses narrower than one `wb_clk_i` period are not guaranteed to be captured.

## Configuration
- `PLIC_GW_EDGE_COUNT_EN` defined: each source gets a 3-bit saturating edge counter.
  - An edge-mode `req` while PENDING or INSERVICE increments the counter.
  - On complete with count > 0: go to PENDING and decrement.
  - Same-cycle edge and decrement: net 0.
  - An edge arriving at count==7 sets `overrun_o`.
  - Level mode never counts.
- Not defined: no counter is built. Edges while PENDING merge. Edges while INSERVICE drop and set `overrun_o`.

## Test plan
- Reset: hold `wb_rst_n_i`=0 for 3 cycles with `src_i`=8'hFE → all outputs 0. Release → `pending_o`=8'hFE after 3 edges (level mode).
- Edge source 2: pulse `src_i[2]` for 2 cycles → `pending_o[2]`=1 at +3. Claim ID 2 → `pending_o[2]`=0, `busy_o[2]`=1. Complete ID 2 → `busy_o[2]`=0, and there is no re-pend.
- Level source 1 held high: claim, then complete → `pending_o[1]` reasserts exactly 1 cycle after `busy_o[1]` falls. Drop `src_i[1]` before complete → no re-pend.
- Bogus handshakes: claim ID 0, claim ID 9, complete ID 3 while IDLE → no state change, all outputs unchanged.
- Overrun (macro off): edge on source 3, claim, then 2 more edges → `overrun_o[3]`=1. Complete → `overrun_o[3]`=0, `pending_o[3]`=0.
- Counting (macro on): edge, claim, then 3 edges while INSERVICE → three complete/claim rounds each re-pend. 8 extra edges → count saturates at 7 and `overrun_o`=1.

Source files
------------

// File: rtl/plic_gateway.sv
// Interrupt gateway: synchronizes raw source lines and tracks each one through IDLE/PENDING/INSERVICE.
// Optional build macro PLIC_GW_EDGE_COUNT_EN adds a 3-bit saturating edge counter per source.
module plic_gateway #(
  parameter int NSRC        = 8,
  parameter int IDW         = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [NSRC-1:0] src_i,
  input  logic [NSRC-1:0] edge_sel_i,
  input  logic            claim_i,
  input  logic [IDW-1:0]  claim_id_i,
  input  logic            complete_i,
  input  logic [IDW-1:0]  complete_id_i,
  output logic [NSRC-1:0] pending_o,
  output logic [NSRC-1:0] busy_o,
  output logic [NSRC-1:0] overrun_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    INSERVICE = 2'd2
  } state_t;

  // Slot 0 is reserved; its inputs are intentionally ignored.
  logic unused_slot0_s;
  assign unused_slot0_s = src_i[0] ^ edge_sel_i[0];

  assign pending_o[0] = 1'b0;
  assign busy_o[0]    = 1'b0;
  assign overrun_o[0] = 1'b0;

  for (genvar i = 1; i < NSRC; i++) begin : g_src
    localparam logic [IDW-1:0] SRC_ID = IDW'(i);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   sync_s;
    logic                   edge_req_s;
    logic                   req_s;
    logic                   claim_hit_s;
    logic                   complete_hit_s;
    state_t                 state_r;
    state_t                 state_s;
    logic                   overrun_r;
    logic                   overrun_s;
    logic                   pending_r;
    logic                   busy_r;

    assign sync_s         = sync_r[SYNC_STAGES-1];
    assign edge_req_s     = edge_sel_i[i] & sync_s & ~prev_r;
    assign req_s          = edge_sel_i[i] ? edge_req_s : sync_s;
    assign claim_hit_s    = claim_i && (claim_id_i == SRC_ID);
    assign complete_hit_s = complete_i && (complete_id_i == SRC_ID);

`ifdef PLIC_GW_EDGE_COUNT_EN
    logic [2:0] cnt_r;
    logic [2:0] cnt_s;

    // Next state with edge counting: queued edges re-pend the source on complete.
    always_comb begin
      state_s   = state_r;
      overrun_s = overrun_r;
      cnt_s     = cnt_r;
      case (state_r)
        IDLE: begin
          if (req_s) state_s = PENDING;
          else       state_s = IDLE;
        end
        PENDING: begin
          if (claim_hit_s) state_s = INSERVICE;
          else             state_s = PENDING;
          if (edge_req_s) begin
            if (cnt_r == 3'd7) overrun_s = 1'b1;
            else               cnt_s     = cnt_r + 3'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end
        INSERVICE: begin
          if (complete_hit_s) begin
            overrun_s = 1'b0;
            if (cnt_r != 3'd0) begin
              state_s = PENDING;
              if (edge_req_s) cnt_s = cnt_r;
              else            cnt_s = cnt_r - 3'd1;
            end else if (edge_req_s) begin
              // An edge landing on the completing cycle is served directly.
              state_s = PENDING;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = INSERVICE;
            if (edge_req_s) begin
              if (cnt_r == 3'd7) overrun_s = 1'b1;
              else               cnt_s     = cnt_r + 3'd1;
            end else begin
              cnt_s = cnt_r;
            end
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 3'd0;
        end
      endcase
    end

    // Edge counter register.
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) cnt_r <= 3'd0;
      else             cnt_r <= cnt_s;
    end
`else
    // Next state without counting: edges merge while pending and are lost while in service.
    always_comb begin
      state_s   = state_r;
      overrun_s = overrun_r;
      case (state_r)
        IDLE: begin
          if (req_s) state_s = PENDING;
          else       state_s = IDLE;
        end
        PENDING: begin
          if (claim_hit_s) state_s = INSERVICE;
          else             state_s = PENDING;
        end
        INSERVICE: begin
          if (complete_hit_s) begin
            state_s   = IDLE;
            overrun_s = edge_req_s;
          end else begin
            state_s   = INSERVICE;
            overrun_s = overrun_r | edge_req_s;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
`endif

    // Synchronizer chain plus one sample of history for edge detection.
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
        sync_r <= '0;
        prev_r <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], src_i[i]};
        prev_r <= sync_s;
      end
    end

    // State register and registered output decode.
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
        state_r   <= IDLE;
        overrun_r <= 1'b0;
        pending_r <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        state_r   <= state_s;
        overrun_r <= overrun_s;
        pending_r <= (state_s == PENDING);
        busy_r    <= (state_s == INSERVICE);
      end
    end

    assign pending_o[i] = pending_r;
    assign busy_o[i]    = busy_r;
    assign overrun_o[i] = overrun_r;
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway (default parameters).
module tb_plic_gateway;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic [7:0] edge_sel;
  logic       claim;
  logic [4:0] claim_id;
  logic       complete;
  logic [4:0] complete_id;
  logic [7:0] pending;
  logic [7:0] busy;
  logic [7:0] overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plic_gateway dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .src_i         (src),
    .edge_sel_i    (edge_sel),
    .claim_i       (claim),
    .claim_id_i    (claim_id),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .pending_o     (pending),
    .busy_o        (busy),
    .overrun_o     (overrun)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_claim(input logic [4:0] id);
    claim = 1'b1; claim_id = id;
    tick();
    claim = 1'b0; claim_id = 5'd0;
  endtask

  task automatic do_complete(input logic [4:0] id);
    complete = 1'b1; complete_id = id;
    tick();
    complete = 1'b0; complete_id = 5'd0;
  endtask

  // Two-cycle high pulse followed by two low cycles so the synchronizer settles.
  task automatic pulse(input int idx);
    src[idx] = 1'b1;
    tick(); tick();
    src[idx] = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; src = 8'hFE; edge_sel = 8'h00;
    claim = 1'b0; claim_id = 5'd0; complete = 1'b0; complete_id = 5'd0;
    repeat (3) tick();
    check("rst_pending", pending, 8'h00);
    check("rst_busy", busy, 8'h00);
    check("rst_overrun", overrun, 8'h00);

    rst_n = 1'b1;
    tick(); check("lat_edge1", pending, 8'h00);
    tick(); check("lat_edge2", pending, 8'h00);
    tick(); check("lat_edge3", pending, 8'hFE);

    do_claim(5'd1);
    check("claim1_pending", pending, 8'hFC);
    check("claim1_busy", busy, 8'h02);
    rst_n = 1'b0; src = 8'h00;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", busy, 8'h00);
    check("rst_mid_pending", pending, 8'h00);
    tick();
    check("rst_mid_quiet", pending, 8'h00);

    // Edge source 2
    edge_sel = 8'h0C;
    src[2] = 1'b1;
    tick(); tick();
    check("e2_early", pending, 8'h00);
    src[2] = 1'b0;
    tick();
    check("e2_pending", pending, 8'h04);
    do_claim(5'd2);
    check("e2_claim_pending", pending, 8'h00);
    check("e2_claim_busy", busy, 8'h04);
    do_complete(5'd2);
    check("e2_complete_busy", busy, 8'h00);
    tick();
    check("e2_no_repend", pending, 8'h00);

    // Level source 1 held high
    src[1] = 1'b1;
    repeat (3) tick();
    check("l1_pending", pending, 8'h02);
    do_claim(5'd1);
    check("l1_claim_busy", busy, 8'h02);
    check("l1_claim_pending", pending, 8'h00);
    do_complete(5'd1);
    check("l1_complete_busy", busy, 8'h00);
    check("l1_complete_pending", pending, 8'h00);
    tick();
    check("l1_repend", pending, 8'h02);
    do_claim(5'd1);
    src[1] = 1'b0;
    tick(); tick();
    do_complete(5'd1);
    check("l1_drop_busy", busy, 8'h00);
    tick();
    check("l1_drop_no_repend", pending, 8'h00);

    // Bogus handshakes with source 1 pending
    src[1] = 1'b1;
    repeat (3) tick();
    check("bogus_pre", pending, 8'h02);
    do_claim(5'd0);
    do_claim(5'd9);
    do_claim(5'd2);
    do_complete(5'd3);
    do_complete(5'd1);
    check("bogus_pending", pending, 8'h02);
    check("bogus_busy", busy, 8'h00);
    check("bogus_overrun", overrun, 8'h00);
    do_claim(5'd1);
    src[1] = 1'b0;
    tick(); tick();
    do_complete(5'd1);
    tick();
    check("bogus_cleanup", pending, 8'h00);

`ifndef PLIC_GW_EDGE_COUNT_EN
    // Overrun on edge source 3
    pulse(3);
    check("ovr_pending", pending, 8'h08);
    do_claim(5'd3);
    check("ovr_busy", busy, 8'h08);
    pulse(3);
    pulse(3);
    check("ovr_set", overrun, 8'h08);
    check("ovr_no_pend", pending, 8'h00);
    do_complete(5'd3);
    check("ovr_clear", overrun, 8'h00);
    check("ovr_busy_clear", busy, 8'h00);
    tick();
    check("ovr_no_repend", pending, 8'h00);
`else
    // Edge counting on source 3
    pulse(3);
    check("cnt_pending", pending, 8'h08);
    do_claim(5'd3);
    pulse(3); pulse(3); pulse(3);
    check("cnt_busy", busy, 8'h08);
    check("cnt_no_overrun", overrun, 8'h00);
    for (int r = 0; r < 3; r++) begin
      do_complete(5'd3);
      check("cnt_repend", pending, 8'h08);
      do_claim(5'd3);
      check("cnt_reclaim", busy, 8'h08);
    end
    do_complete(5'd3);
    check("cnt_final_busy", busy, 8'h00);
    tick();
    check("cnt_final_pending", pending, 8'h00);
    pulse(3);
    do_claim(5'd3);
    repeat (8) pulse(3);
    check("cnt_saturate_overrun", overrun, 8'h08);
    do_complete(5'd3);
    check("cnt_sat_clear", overrun, 8'h00);
    check("cnt_sat_repend", pending, 8'h08);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
